// File: rtl/bp_pht_sat_if.sv
// rtl/bp_pht_sat_if.sv - request/response bundle of the pattern history table
interface bp_pht_sat_if #(
    parameter int ADDR_W = 10,
    parameter int CTR_W  = 2
);
    logic              flush_i;
    logic              ready_o;
    logic              rd_en_i;
    logic [ADDR_W-1:0] rd_idx_i;
    logic [ADDR_W-1:0] rd_hist_i;
    logic              rd_valid_o;
    logic [CTR_W-1:0]  rd_cnt_o;
    logic              rd_taken_o;
    logic              up_en_i;
    logic [ADDR_W-1:0] up_idx_i;
    logic [ADDR_W-1:0] up_hist_i;
    logic              up_taken_i;

    modport master (
        output flush_i, rd_en_i, rd_idx_i, rd_hist_i,
        output up_en_i, up_idx_i, up_hist_i, up_taken_i,
        input  ready_o, rd_valid_o, rd_cnt_o, rd_taken_o
    );

    modport slave (
        input  flush_i, rd_en_i, rd_idx_i, rd_hist_i,
        input  up_en_i, up_idx_i, up_hist_i, up_taken_i,
        output ready_o, rd_valid_o, rd_cnt_o, rd_taken_o
    );
endinterface

// File: rtl/bp_pht_sat.sv
// rtl/bp_pht_sat.sv - saturating-counter pattern history table with clear sweep
module bp_pht_sat #(
    parameter int ADDR_W   = 10,
    parameter int CTR_W    = 2,
    parameter int INIT_VAL = 1,
    parameter int HASH_EN  = 0,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           reset,
    bp_pht_sat_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_ZERO = '0;
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_VAL);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nx;
    logic              w_sweep_we;
    logic              r_rd_valid;
    logic [CTR_W-1:0]  r_rd_cnt;
    logic [CTR_W-1:0]  r_mem [DEPTH];

    logic              w_run;
    logic              w_rd_acc;
    logic              w_up_acc;
    logic [ADDR_W-1:0] w_rd_e;
    logic [ADDR_W-1:0] w_up_e;
    logic [CTR_W-1:0]  w_up_old;
    logic [CTR_W-1:0]  w_up_new;
    logic [CTR_W-1:0]  w_rd_data;

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] c, input logic taken);
        if (taken) begin
            return (c == CTR_MAX) ? c : c + CTR_ONE;
        end
        return (c == CTR_ZERO) ? c : c - CTR_ONE;
    endfunction

    assign w_run    = (r_state == ST_RUN);
    assign w_rd_acc = w_run && bus.rd_en_i && !bus.flush_i;
    assign w_up_acc = w_run && bus.up_en_i && !bus.flush_i;
    assign w_rd_e   = (HASH_EN != 0) ? (bus.rd_idx_i ^ bus.rd_hist_i) : bus.rd_idx_i;
    assign w_up_e   = (HASH_EN != 0) ? (bus.up_idx_i ^ bus.up_hist_i) : bus.up_idx_i;
    assign w_up_old = r_mem[w_up_e];
    assign w_up_new = sat_step(w_up_old, bus.up_taken_i);

    // Collision: the update lands at the same edge, so forwarding selects old or new.
    assign w_rd_data = ((BYPASS != 0) && w_up_acc && (w_rd_e == w_up_e)) ? w_up_new : r_mem[w_rd_e];

    always_comb begin
        w_state_nx   = r_state;
        w_clr_ptr_nx = r_clr_ptr;
        w_sweep_we   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (bus.flush_i) begin
                    w_clr_ptr_nx = '0;
                end else begin
                    w_sweep_we   = 1'b1;
                    w_clr_ptr_nx = r_clr_ptr + 1'b1;
                    if (&r_clr_ptr) begin
                        w_state_nx = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.flush_i) begin
                    w_state_nx   = ST_INIT;
                    w_clr_ptr_nx = '0;
                end
            end
            default: begin
                w_state_nx   = ST_INIT;
                w_clr_ptr_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_INIT;
            r_clr_ptr  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_cnt   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_clr_ptr  <= w_clr_ptr_nx;
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_cnt <= w_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_sweep_we) begin
                r_mem[r_clr_ptr] <= CTR_INIT;
            end else if (w_up_acc) begin
                r_mem[w_up_e] <= w_up_new;
            end
        end
    end

    assign bus.ready_o    = w_run;
    assign bus.rd_valid_o = r_rd_valid;
    assign bus.rd_cnt_o   = r_rd_cnt;
    assign bus.rd_taken_o = r_rd_cnt[CTR_W-1];
endmodule
